// File: rtl/mem_copy_engine_pkg.sv
// Shared memory-bus definitions: command encodings, fixed I/O addresses
// and the copy engine state type.
package mem_bus_pkg;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [8:0] LED_ADDR = 9'h100;
  localparam logic [8:0] SW_ADDR  = 9'h140;
  localparam logic [8:0] RAM_TOP  = 9'h0FF;

  // ST_ prefix keeps the state names clear of the RD_WAIT parameter.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR       = 3'd3,
    ST_DONE     = 3'd4
  } copy_state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Block copy engine: a bus initiator that reads LEN words from SRC and
// writes them to DST, one word at a time (read, wait, write).
//
// Bus handshake: there is no valid/ready pair. mem_cmd is the command
// qualifier; a read is held at a stable address for 1+RD_WAIT cycles and
// read_data is sampled on the last of those edges; a write is presented
// for exactly one cycle and the responder commits it on that cycle's
// closing edge. Every output comes straight from a flop.
module mem_copy_engine
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] xfer_count,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W = (RD_WAIT < 1) ? 1 : $clog2(RD_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_FIRST = CNT_W'(1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(RD_WAIT);

  copy_state_t       state_q, state_d;
  logic              armed_q, armed_d;
  logic [ADDR_W-1:0] cur_src_q, cur_src_d;
  logic [ADDR_W-1:0] cur_dst_q, cur_dst_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [ADDR_W-1:0] xfer_count_q, xfer_count_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        mem_cmd_q, mem_cmd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  // write_data_q doubles as the data buffer: it captures read_data and
  // then holds it through the write and beyond.
  logic [DATA_W-1:0] write_data_q, write_data_d;

  // Next-state and next-output logic; bus outputs are computed for the
  // state being entered so they are registered with it.
  always_comb begin
    state_d      = state_q;
    armed_d      = 1'b1;
    cur_src_d    = cur_src_q;
    cur_dst_d    = cur_dst_q;
    remaining_d  = remaining_q;
    xfer_count_d = xfer_count_q;
    wait_cnt_d   = wait_cnt_q;
    write_data_d = write_data_q;
    mem_cmd_d    = MEM_NONE;
    mem_addr_d   = '0;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // armed_q is low on the first edge after reset release, so a start
        // coincident with that release is dropped.
        if (start && armed_q) begin
          cur_src_d    = src_addr;
          cur_dst_d    = dst_addr;
          remaining_d  = len;
          xfer_count_d = '0;
          if (len != '0) begin
            state_d    = ST_RD_ISSUE;
            mem_cmd_d  = MEM_READ;
            mem_addr_d = src_addr;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_RD_ISSUE: begin
        if (RD_WAIT == 0) begin
          write_data_d = read_data;
          state_d      = ST_WR;
          mem_cmd_d    = MEM_WRITE;
          mem_addr_d   = cur_dst_q;
        end else begin
          state_d    = ST_RD_WAIT;
          wait_cnt_d = WAIT_FIRST;
          mem_cmd_d  = MEM_READ;
          mem_addr_d = cur_src_q;
        end
      end

      ST_RD_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          write_data_d = read_data;
          state_d      = ST_WR;
          mem_cmd_d    = MEM_WRITE;
          mem_addr_d   = cur_dst_q;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_FIRST;
          mem_cmd_d  = MEM_READ;
          mem_addr_d = cur_src_q;
        end
      end

      ST_WR: begin
        // Address arithmetic wraps modulo 2^ADDR_W by construction.
        xfer_count_d = xfer_count_q + ADDR_W'(1);
        cur_src_d    = cur_src_q + ADDR_W'(1);
        cur_dst_d    = cur_dst_q + ADDR_W'(1);
        remaining_d  = remaining_q - ADDR_W'(1);
        if (remaining_q == ADDR_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d    = ST_RD_ISSUE;
          mem_cmd_d  = MEM_READ;
          mem_addr_d = cur_src_q + ADDR_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops the bus to idle immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      armed_q      <= 1'b0;
      cur_src_q    <= '0;
      cur_dst_q    <= '0;
      remaining_q  <= '0;
      xfer_count_q <= '0;
      wait_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_cmd_q    <= MEM_NONE;
      mem_addr_q   <= '0;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      cur_src_q    <= cur_src_d;
      cur_dst_q    <= cur_dst_d;
      remaining_q  <= remaining_d;
      xfer_count_q <= xfer_count_d;
      wait_cnt_q   <= wait_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mem_cmd_q    <= mem_cmd_d;
      mem_addr_q   <= mem_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign xfer_count = xfer_count_q;
  assign mem_cmd    = mem_cmd_q;
  assign mem_addr   = mem_addr_q;
  assign write_data = write_data_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: RAM with registered dout, LED and switch
// decode, a bus monitor, and a word-by-word reference model of the copy.
module tb_mem_copy_engine;
  import mem_bus_pkg::*;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int RD_WAIT_TB = 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0, dst_addr = '0, len = '0;
  logic          busy, done;
  logic [AW-1:0] xfer_count, mem_addr;
  logic [1:0]    mem_cmd;
  logic [DW-1:0] write_data, read_data;
  logic [2:0]    dbg_state;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RD_WAIT_TB)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .busy(busy), .done(done),
    .xfer_count(xfer_count), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .read_data(read_data), .dbg_state(dbg_state)
  );

  // ---------------- responder: RAM + LEDs + switches ----------------
  logic [15:0] ram [256];
  logic [15:0] rd_dout = '0;
  logic [15:0] ledr = '0;
  logic [7:0]  sw = '0;
  logic        init_en = 1'b0;
  int          init_seed = 0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  function automatic logic [15:0] fill_word(int i, int seed);
    return 16'(i * 40503 + seed * 131 + (i >> 3));
  endfunction

  always @(posedge clk) begin
    if (mem_addr <= RAM_TOP) rd_dout <= ram[mem_addr[7:0]];
    else if (mem_addr == SW_ADDR) rd_dout <= {8'h00, sw};
    else rd_dout <= '0;
    if (init_en) begin
      for (int i = 0; i < 256; i++) ram[i] <= fill_word(i, init_seed);
      ledr <= '0;
    end else if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (mem_cmd == MEM_WRITE) begin
      if (mem_addr <= RAM_TOP) ram[mem_addr[7:0]] <= write_data;
      else if (mem_addr == LED_ADDR) ledr <= write_data;
    end
  end
  assign read_data = rd_dout;

  // ---------------- bus monitor ----------------
  logic [AW-1:0] act_rd_addr_q[$];
  int            act_rd_len_q[$];
  logic [AW-1:0] act_wr_addr_q[$];
  logic [DW-1:0] act_wr_data_q[$];
  int            proto_err = 0;
  int            rd_run = 0;
  logic [AW-1:0] rd_addr_hold = '0;
  logic [1:0]    prev_cmd = MEM_NONE;

  always @(negedge clk) begin
    if (!reset_n) begin
      rd_run = 0;
      prev_cmd = MEM_NONE;
    end else begin
      if (mem_cmd === 2'b11) proto_err++;
      if (mem_cmd === MEM_NONE && mem_addr !== '0) proto_err++;
      if (mem_cmd === MEM_READ) begin
        if (rd_run == 0) rd_addr_hold = mem_addr;
        else if (mem_addr !== rd_addr_hold) proto_err++;
        rd_run++;
      end else if (rd_run != 0) begin
        act_rd_addr_q.push_back(rd_addr_hold);
        act_rd_len_q.push_back(rd_run);
        rd_run = 0;
      end
      if (mem_cmd === MEM_WRITE) begin
        if (prev_cmd === MEM_WRITE) proto_err++;
        act_wr_addr_q.push_back(mem_addr);
        act_wr_data_q.push_back(write_data);
      end
      prev_cmd = mem_cmd;
    end
  end

  // ---------------- reference model ----------------
  logic [15:0]   exp_ram [256];
  logic [15:0]   exp_led = '0;
  logic [AW-1:0] exp_rd_q[$];
  logic [AW-1:0] exp_wr_addr_q[$];
  logic [DW-1:0] exp_wr_data_q[$];

  function automatic logic [15:0] model_read(logic [AW-1:0] a);
    if (a <= 9'h0FF) return exp_ram[a[7:0]];
    if (a == 9'h140) return {8'h00, sw};
    return 16'h0000;
  endfunction

  // Copy n words in ascending order, one word at a time, so overlapping
  // regions smear exactly as a word-serial copy would.
  task automatic model_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
    logic [AW-1:0] ra, wa;
    logic [15:0]   v;
    for (int i = 0; i < n; i++) begin
      ra = AW'(int'(s) + i);
      wa = AW'(int'(d) + i);
      v  = model_read(ra);
      exp_rd_q.push_back(ra);
      exp_wr_addr_q.push_back(wa);
      exp_wr_data_q.push_back(v);
      if (wa <= 9'h0FF) exp_ram[wa[7:0]] = v;
      else if (wa == 9'h100) exp_led = v;
    end
  endtask

  task automatic clear_expect();
    exp_rd_q.delete();
    exp_wr_addr_q.delete();
    exp_wr_data_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic init_ram(input int seed);
    init_seed = seed;
    init_en = 1'b1;
    @(posedge clk); #1;
    init_en = 1'b0;
    for (int i = 0; i < 256; i++) exp_ram[i] = fill_word(i, seed);
    exp_led = '0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] v);
    pl_addr = a; pl_data = v; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
    exp_ram[a] = v;
  endtask

  // Starts one copy and measures it. lat counts edges from the accepting
  // edge (inclusive) to the edge after which done is seen; -1 on timeout.
  task automatic do_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n,
                         output int lat, output int busy_cyc, output logic [AW-1:0] xfer_at_done,
                         output logic done_after);
    @(negedge clk);
    src_addr = s; dst_addr = d; len = AW'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cyc = (busy === 1'b1) ? 1 : 0;
    lat = -1;
    xfer_at_done = 'x;
    for (int k = 1; k <= 3 * n + 30; k++) begin
      @(posedge clk); #1;
      src_addr = AW'($urandom); dst_addr = AW'($urandom); len = AW'($urandom);
      if (done === 1'b1) begin
        lat = k + 1;
        xfer_at_done = xfer_count;
        break;
      end
      if (busy === 1'b1) busy_cyc++;
    end
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic traffic_errs(input int rd_base, input int wr_base, input int perr_base, output int n);
    n = 0;
    if (act_rd_addr_q.size() - rd_base != exp_rd_q.size()) n++;
    else foreach (exp_rd_q[i])
      if (act_rd_addr_q[rd_base + i] !== exp_rd_q[i] || act_rd_len_q[rd_base + i] != 1 + RD_WAIT_TB) n++;
    if (act_wr_addr_q.size() - wr_base != exp_wr_addr_q.size()) n++;
    else foreach (exp_wr_addr_q[i])
      if (act_wr_addr_q[wr_base + i] !== exp_wr_addr_q[i] || act_wr_data_q[wr_base + i] !== exp_wr_data_q[i]) n++;
    n += proto_err - perr_base;
  endtask

  task automatic mem_errs(output int n);
    n = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== exp_ram[i]) n++;
    if (ledr !== exp_led) n++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    total++; if (mem_cmd !== 2'b00) begin bad++; $display("FAIL reset_mem_cmd got=%b exp=00", mem_cmd); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    total++; if (xfer_count !== '0) begin bad++; $display("FAIL reset_xfer got=%0d exp=0", xfer_count); end
    total++; if (write_data !== '0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", write_data); end
    total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    total++; if (busy !== 1'b0 || mem_cmd !== 2'b00) begin bad++; $display("FAIL post_reset_idle busy=%b cmd=%b exp=0/00", busy, mem_cmd); end
  endtask

  task automatic test_block_copy();
    int lat, bc, te, me, rb, wb, pb; logic [AW-1:0] xc; logic da;
    init_ram(1);
    preload(8'h10, 16'h00A1); preload(8'h11, 16'h00B2);
    preload(8'h12, 16'h00C3); preload(8'h13, 16'h00D4);
    clear_expect(); model_copy(9'h010, 9'h040, 4);
    rb = act_rd_addr_q.size(); wb = act_wr_addr_q.size(); pb = proto_err;
    do_copy(9'h010, 9'h040, 4, lat, bc, xc, da);
    total++; if (lat != 14) begin bad++; $display("FAIL t1_latency got=%0d exp=14", lat); end
    total++; if (bc != 13) begin bad++; $display("FAIL t1_busy_cycles got=%0d exp=13", bc); end
    total++; if (xc !== 9'd4) begin bad++; $display("FAIL t1_xfer_count got=%0d exp=4", xc); end
    total++; if (da !== 1'b0) begin bad++; $display("FAIL t1_done_width got=%b exp=0", da); end
    total++; if (ram[8'h43] !== 16'h00D4) begin bad++; $display("FAIL t1_ram43 got=%h exp=00d4", ram[8'h43]); end
    traffic_errs(rb, wb, pb, te);
    total++; if (te != 0) begin bad++; $display("FAIL t1_traffic errs=%0d exp=0", te); end
    mem_errs(me);
    total++; if (me != 0) begin bad++; $display("FAIL t1_memory errs=%0d exp=0", me); end
  endtask

  task automatic test_zero_len();
    int lat, bc, te, rb, wb, pb; logic [AW-1:0] xc; logic da;
    clear_expect();
    rb = act_rd_addr_q.size(); wb = act_wr_addr_q.size(); pb = proto_err;
    do_copy(9'h033, 9'h077, 0, lat, bc, xc, da);
    total++; if (lat != 2) begin bad++; $display("FAIL t2_latency got=%0d exp=2", lat); end
    total++; if (bc != 1) begin bad++; $display("FAIL t2_busy_cycles got=%0d exp=1", bc); end
    total++; if (xc !== 9'd0) begin bad++; $display("FAIL t2_xfer_count got=%0d exp=0", xc); end
    traffic_errs(rb, wb, pb, te);
    total++; if (te != 0) begin bad++; $display("FAIL t2_no_traffic errs=%0d exp=0", te); end
  endtask

  task automatic test_wrap();
    int lat, bc, te, me, rb, wb, pb; logic [AW-1:0] xc; logic da;
    clear_expect(); model_copy(9'h1FE, 9'h020, 3);
    rb = act_rd_addr_q.size(); wb = act_wr_addr_q.size(); pb = proto_err;
    do_copy(9'h1FE, 9'h020, 3, lat, bc, xc, da);
    total++; if (lat != 11) begin bad++; $display("FAIL t3_latency got=%0d exp=11", lat); end
    total++; if (act_rd_addr_q.size() == rb + 3 && act_rd_addr_q[rb + 2] !== 9'h000) begin
      bad++; $display("FAIL t3_wrap_read got=%h exp=000", act_rd_addr_q[rb + 2]); end
    traffic_errs(rb, wb, pb, te);
    total++; if (te != 0) begin bad++; $display("FAIL t3_traffic errs=%0d exp=0", te); end
    mem_errs(me);
    total++; if (me != 0) begin bad++; $display("FAIL t3_memory errs=%0d exp=0", me); end
  endtask

  task automatic test_switch_to_led();
    int lat, bc, te, rb, wb, pb; logic [AW-1:0] xc; logic da;
    sw = 8'h5A;
    clear_expect(); model_copy(9'h140, 9'h100, 1);
    rb = act_rd_addr_q.size(); wb = act_wr_addr_q.size(); pb = proto_err;
    do_copy(9'h140, 9'h100, 1, lat, bc, xc, da);
    total++; if (ledr !== 16'h005A) begin bad++; $display("FAIL t4_ledr got=%h exp=005a", ledr); end
    total++; if (act_wr_data_q.size() != wb + 1 || act_wr_data_q[wb] !== 16'h005A || act_wr_addr_q[wb] !== 9'h100) begin
      bad++; $display("FAIL t4_write_cycle writes=%0d exp=1 of 005a@100", act_wr_data_q.size() - wb); end
    traffic_errs(rb, wb, pb, te);
    total++; if (te != 0) begin bad++; $display("FAIL t4_traffic errs=%0d exp=0", te); end
  endtask

  task automatic test_random();
    int lat, bc, te, me, rb, wb, pb, n; logic [AW-1:0] s, d, xc; logic da;
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(0, 6);
      s = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 511)) : AW'($urandom_range(0, 255));
      d = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 511)) : AW'($urandom_range(0, 255));
      sw = 8'($urandom);
      clear_expect(); model_copy(s, d, n);
      rb = act_rd_addr_q.size(); wb = act_wr_addr_q.size(); pb = proto_err;
      do_copy(s, d, n, lat, bc, xc, da);
      total++; if (lat != 3 * n + 2) begin bad++; $display("FAIL rnd_latency it=%0d got=%0d exp=%0d", it, lat, 3 * n + 2); end
      total++; if (xc !== AW'(n)) begin bad++; $display("FAIL rnd_xfer it=%0d got=%0d exp=%0d", it, xc, n); end
      traffic_errs(rb, wb, pb, te);
      total++; if (te != 0) begin bad++; $display("FAIL rnd_traffic it=%0d errs=%0d exp=0", it, te); end
      mem_errs(me);
      total++; if (me != 0) begin bad++; $display("FAIL rnd_memory it=%0d errs=%0d exp=0", it, me); end
    end
  endtask

  // len=8 copy, a second start mid-flight, then reset after three words.
  task automatic test_abort();
    int te, me, rb, wb, pb, done_seen;
    init_ram(7);
    clear_expect(); model_copy(9'h060, 9'h080, 3);
    rb = act_rd_addr_q.size(); wb = act_wr_addr_q.size(); pb = proto_err;
    done_seen = 0;
    @(negedge clk);
    src_addr = 9'h060; dst_addr = 9'h080; len = 9'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
      start = (k == 4);
      if (k == 4) begin src_addr = 9'h000; dst_addr = 9'h0C0; len = 9'd2; end
    end
    #2; reset_n = 1'b0; #1;
    total++; if (mem_cmd !== 2'b00 || mem_addr !== '0) begin bad++; $display("FAIL t5_async_cmd got=%b@%h exp=00@0", mem_cmd, mem_addr); end
    total++; if (xfer_count !== '0 || busy !== 1'b0) begin bad++; $display("FAIL t5_async_clear xfer=%0d busy=%b exp=0/0", xfer_count, busy); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    @(negedge clk);
    reset_n = 1'b1; start = 1'b1; src_addr = 9'h000; dst_addr = 9'h0C0; len = 9'd2;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b0 || dbg_state !== 3'd0) begin bad++; $display("FAIL t5_start_at_release busy=%b state=%0d exp=0/0", busy, dbg_state); end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    total++; if (done_seen != 0) begin bad++; $display("FAIL t5_no_done got=%0d exp=0", done_seen); end
    traffic_errs(rb, wb, pb, te);
    total++; if (te != 0) begin bad++; $display("FAIL t5_traffic errs=%0d exp=0", te); end
    mem_errs(me);
    total++; if (me != 0) begin bad++; $display("FAIL t5_memory errs=%0d exp=0", me); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_block_copy();
    test_zero_len();
    test_wrap();
    test_switch_to_led();
    test_random();
    test_abort();
    test_block_copy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
